// File: rtl/sha_w_sched_pkg.sv
// Shared SHA-256 definitions for the message-schedule expander: word/message/hash sizes,
// the sigma0/sigma1 schedule functions as macros, FSM state encodings and a message-word helper.
// Latency: n/a (definitions only). Backpressure: n/a.
`ifndef SHA_VH
`define SHA_VH

`define WORD_S 32
`define MSG_S  512
`define H_SIZE 256

// Rotate-right of a 32-bit operand; used only in 32-bit contexts so the left shift truncates.
`define SHA_ROR(x, n)  (((x) >> (n)) | ((x) << (32 - (n))))
`define SHA_SIG0(x)    (`SHA_ROR(x, 7)  ^ `SHA_ROR(x, 18) ^ ((x) >> 3))
`define SHA_SIG1(x)    (`SHA_ROR(x, 17) ^ `SHA_ROR(x, 19) ^ ((x) >> 10))

`define SHA_ST_IDLE   2'd0
`define SHA_ST_EXPAND 2'd1
`define SHA_ST_HOLD   2'd2

`endif

package sha_w_sched_pkg;

    localparam int WORD_W = `WORD_S;
    localparam int MSG_W  = `MSG_S;
    localparam int H_W    = `H_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE   = `SHA_ST_IDLE,
        ST_EXPAND = `SHA_ST_EXPAND,
        ST_HOLD   = `SHA_ST_HOLD
    } state_t;

    // Word t of a message block; word 0 is the most significant 32 bits.
    // Out-of-range t yields zero (only reached by lanes whose result is discarded).
    function automatic logic [WORD_W-1:0] msg_word(input logic [MSG_W-1:0] m, input int t);
        msg_word = '0;
        for (int i = 0; i < 16; i++) begin
            if (t == i) begin
                msg_word = m[MSG_W-1-WORD_W*i -: WORD_W];
            end
        end
    endfunction

endpackage

// File: rtl/sha_w_word.sv
// One SHA-256 schedule word for t>=16: sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16] mod 2^32.
// Latency: combinational. Backpressure: none.
// Ports: w2_i/w7_i/w15_i/w16_i = W[t-2]/W[t-7]/W[t-15]/W[t-16]; w_o = W[t].
module sha_w_word
    import sha_w_sched_pkg::*;
(
    input  logic [WORD_W-1:0] w2_i,
    input  logic [WORD_W-1:0] w7_i,
    input  logic [WORD_W-1:0] w15_i,
    input  logic [WORD_W-1:0] w16_i,
    output logic [WORD_W-1:0] w_o
);

    logic [WORD_W-1:0] s0;
    logic [WORD_W-1:0] s1;

    assign s0  = `SHA_SIG0(w15_i);
    assign s1  = `SHA_SIG1(w2_i);
    assign w_o = s1 + w7_i + s0 + w16_i;

endmodule

// File: rtl/sha_w_sched.sv
// SHA-256 message-schedule expander: captures M/Hin/nonce, produces W[0..NWORDS-1] at WPC words/cycle.
// Latency: out_valid rises NWORDS/WPC cycles after the accept edge; back-to-back accept from HOLD.
// Backpressure: results held bit-stable in HOLD while out_ready=0; in_ready=0 while expanding.
// Ports: clk/reset (async active-high); in_valid/in_ready + nonce/M/Hin input handshake;
//        out_valid/out_ready + nonce_out/W/H output handshake, word i of the schedule at W[i*32 +: 32].
module sha_w_sched
    import sha_w_sched_pkg::*;
#(
    parameter int NWORDS = 64,
    parameter int WPC    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [`WORD_S-1:0]       nonce,
    input  logic [`MSG_S-1:0]        M,
    input  logic [`H_SIZE-1:0]       Hin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [`WORD_S-1:0]       nonce_out,
    output logic [NWORDS*WORD_W-1:0] W,
    output logic [`H_SIZE-1:0]       H
);

    localparam int IW = $clog2(NWORDS + 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [MSG_W-1:0]  m_q, m_d;
    logic [H_W-1:0]    h_q, h_d;
    logic [WORD_W-1:0] nonce_q, nonce_d;
    logic [WORD_W-1:0] w_q [NWORDS];
    logic [WORD_W-1:0] w_d [NWORDS];
    logic [WORD_W-1:0] lane_w [WPC];
    logic              accept;

    // Registered schedule word at a run-time index; negative/out-of-range indices only
    // occur for lanes that select the message word instead, so their value is irrelevant.
    function automatic logic [WORD_W-1:0] w_at(input int src);
        w_at = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (src == i) begin
                w_at = w_q[i];
            end
        end
    endfunction

    // Lane j produces word idx+j. A source word written earlier in this same cycle comes
    // from the lower lane's combinational result, never from the (not yet updated) register.
    for (genvar j = 0; j < WPC; j++) begin : g_lane
        logic [WORD_W-1:0] w2, w7, w15, w16, exp_w, word;

        if (j >= 2) begin : g_w2_lane
            assign w2 = g_lane[j-2].word;
        end else begin : g_w2_reg
            assign w2 = w_at(int'(idx_q) + j - 2);
        end

        if (j >= 7) begin : g_w7_lane
            assign w7 = g_lane[j-7].word;
        end else begin : g_w7_reg
            assign w7 = w_at(int'(idx_q) + j - 7);
        end

        if (j >= 15) begin : g_w15_lane
            assign w15 = g_lane[j-15].word;
        end else begin : g_w15_reg
            assign w15 = w_at(int'(idx_q) + j - 15);
        end

        // WPC <= 16, so t-16 is always from an earlier cycle.
        assign w16 = w_at(int'(idx_q) + j - 16);

        sha_w_word u_word (
            .w2_i  (w2),
            .w7_i  (w7),
            .w15_i (w15),
            .w16_i (w16),
            .w_o   (exp_w)
        );

        assign word      = (int'(idx_q) + j < 16) ? msg_word(m_q, int'(idx_q) + j) : exp_w;
        assign lane_w[j] = word;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        m_d       = m_q;
        h_d       = h_q;
        nonce_d   = nonce_q;
        w_d       = w_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            ST_EXPAND: begin
                for (int i = 0; i < NWORDS; i++) begin
                    for (int j = 0; j < WPC; j++) begin
                        if (int'(idx_q) + j == i) begin
                            w_d[i] = lane_w[j];
                        end
                    end
                end
                idx_d = idx_q + IW'(WPC);
                if (int'(idx_q) + WPC == NWORDS) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            m_d     = M;
            h_d     = Hin;
            nonce_d = nonce;
            idx_d   = '0;
            state_d = ST_EXPAND;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            m_q     <= '0;
            h_q     <= '0;
            nonce_q <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            m_q     <= m_d;
            h_q     <= h_d;
            nonce_q <= nonce_d;
            for (int i = 0; i < NWORDS; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    for (genvar i = 0; i < NWORDS; i++) begin : g_wout
        assign W[i*WORD_W +: WORD_W] = w_q[i];
    end

    assign H         = h_q;
    assign nonce_out = nonce_q;

endmodule

// File: tb/tb_sha_w_sched.sv
// Bench for sha_w_sched: three instances (WPC=1,4,16, NWORDS=64) share data inputs and out_ready.
// Directed checks for reset, the "abc" block, latency, stall, passthrough and mid-expansion reset;
// a scoreboard run of random back-to-back blocks with random out_ready on the WPC=4 instance.
module tb_sha_w_sched;

    localparam int NRAND = 1000;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [511:0]  m_in;
    logic [255:0]  h_in;
    logic [31:0]   nonce_in;
    logic          out_ready;
    logic          iv1, iv4, iv16;
    logic          ir1, ir4, ir16;
    logic          ov1, ov4, ov16;
    logic [31:0]   no1, no4, no16;
    logic [2047:0] w1, w4, w16;
    logic [255:0]  h1, h4, h16;

    sha_w_sched #(.NWORDS(64), .WPC(1)) dut1 (
        .clk(clk), .reset(rst), .in_valid(iv1), .in_ready(ir1), .nonce(nonce_in), .M(m_in),
        .Hin(h_in), .out_valid(ov1), .out_ready(out_ready), .nonce_out(no1), .W(w1), .H(h1));
    sha_w_sched #(.NWORDS(64), .WPC(4)) dut4 (
        .clk(clk), .reset(rst), .in_valid(iv4), .in_ready(ir4), .nonce(nonce_in), .M(m_in),
        .Hin(h_in), .out_valid(ov4), .out_ready(out_ready), .nonce_out(no4), .W(w4), .H(h4));
    sha_w_sched #(.NWORDS(64), .WPC(16)) dut16 (
        .clk(clk), .reset(rst), .in_valid(iv16), .in_ready(ir16), .nonce(nonce_in), .M(m_in),
        .Hin(h_in), .out_valid(ov16), .out_ready(out_ready), .nonce_out(no16), .W(w16), .H(h16));

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2047:0] w;
        logic [255:0]  h;
        logic [31:0]   n;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        rotr = (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [2047:0] model_w(input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        model_w = '0;
        for (int t = 0; t < 64; t++) model_w[t*32 +: 32] = w[t];
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compares the lowest-indexed differing word (word 63 when all agree).
    task automatic chk_w(input string tag, input logic [2047:0] got, input logic [2047:0] exp);
        int k = 63;
        for (int i = 63; i >= 0; i--) begin
            if (got[i*32 +: 32] !== exp[i*32 +: 32]) k = i;
        end
        chk($sformatf("%s[%0d]", tag, k), {224'd0, got[k*32 +: 32]}, {224'd0, exp[k*32 +: 32]});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_block(output logic [511:0] m, output logic [255:0] h, output logic [31:0] n);
        for (int k = 0; k < 16; k++) m[k*32 +: 32] = $urandom();
        for (int k = 0; k < 8; k++) h[k*32 +: 32] = $urandom();
        n = $urandom();
    endtask

    initial begin
        logic [511:0]  m_abc, m_save;
        logic [2047:0] exp_w;
        logic [255:0]  h_save;
        logic [31:0]   n_save;
        int            lat1, lat4, lat16, n, sent, got, cyc;
        logic          rose, fin, fout;
        exp_t          e;

        rst = 1'b1; iv1 = 0; iv4 = 0; iv16 = 0; out_ready = 0;
        m_in = '0; h_in = '0; nonce_in = '0;
        #12;
        chk("rst_out_valid", ov1, 0);
        chk_w("rst_W", w1, '0);
        chk("rst_H", h1, 0);
        chk("rst_nonce", no1, 0);
        step;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", ir1, 1);

        // "abc" block on all three widths: latency and identical schedules.
        m_abc = '0;
        m_abc[511:480] = 32'h61626380;
        m_abc[31:0]    = 32'h00000018;
        m_in = m_abc; h_in = IV; nonce_in = 32'h12345678;
        exp_w = model_w(m_abc);
        iv1 = 1; iv4 = 1; iv16 = 1;
        step;
        iv1 = 0; iv4 = 0; iv16 = 0;
        lat1 = -1; lat4 = -1; lat16 = -1;
        for (int c = 1; c <= 100; c++) begin
            step;
            if (ov1 && lat1 < 0) lat1 = c;
            if (ov4 && lat4 < 0) lat4 = c;
            if (ov16 && lat16 < 0) lat16 = c;
        end
        chk("lat_wpc1", lat1, 64);
        chk("lat_wpc4", lat4, 16);
        chk("lat_wpc16", lat16, 4);
        chk("abc_W16", w1[16*32 +: 32], 32'h61626380);
        chk("abc_W17", w1[17*32 +: 32], 32'h000F0000);
        chk_w("abc_W_wpc1", w1, exp_w);
        chk_w("abc_W_wpc4", w4, exp_w);
        chk_w("abc_W_wpc16", w16, exp_w);

        // Stall in HOLD: outputs stay put, no input accepted.
        for (int c = 0; c < 10; c++) begin
            step;
            chk("stall_in_ready", ir1, 0);
        end
        chk("stall_out_valid", ov1, 1);
        chk_w("stall_W", w1, exp_w);
        chk("stall_H", h1, IV);
        chk("stall_nonce", no1, 32'h12345678);

        // Back-to-back accept from HOLD; inputs wiggled during expansion must not leak.
        rand_block(m_save, h_save, n_save);
        m_in = m_save; h_in = IV; nonce_in = 32'hDEADBEEF;
        iv1 = 1; out_ready = 1;
        #1;
        chk("hold_in_ready", ir1, 1);
        step;
        iv1 = 0; out_ready = 0;
        exp_w = model_w(m_save);
        n = 0;
        while (!ov1 && n < 200) begin
            step;
            n++;
            if (n == 3) begin
                m_in = ~m_in; h_in = '0; nonce_in = 32'h0;
            end
        end
        chk("lat_b2b", n, 64);
        chk_w("pass_W", w1, exp_w);
        chk("pass_H", h1, IV);
        chk("pass_nonce", no1, 32'hDEADBEEF);
        out_ready = 1;
        step;
        out_ready = 0;
        chk("drain_out_valid", ov1, 0);

        // Reset in the middle of expansion (idx=37).
        rand_block(m_save, h_save, n_save);
        m_in = m_save; h_in = h_save; nonce_in = n_save;
        iv1 = 1;
        step;
        iv1 = 0;
        repeat (37) step;
        rst = 1;
        #1;
        chk("abort_out_valid", ov1, 0);
        chk_w("abort_W", w1, '0);
        chk("abort_H", h1, 0);
        chk("abort_nonce", no1, 0);
        step;
        rst = 0;
        rose = 0;
        repeat (80) begin
            step;
            if (ov1) rose = 1;
        end
        chk("abort_no_output", rose, 0);
        rand_block(m_save, h_save, n_save);
        m_in = m_save; h_in = h_save; nonce_in = n_save;
        iv1 = 1;
        step;
        iv1 = 0;
        n = 0;
        while (!ov1 && n < 200) begin
            step;
            n++;
        end
        chk("lat_after_abort", n, 64);
        chk_w("after_abort_W", w1, model_w(m_save));
        chk("after_abort_H", h1, h_save);
        chk("after_abort_nonce", no1, n_save);
        out_ready = 1;
        step;

        // Random back-to-back blocks with random downstream stalls on the WPC=4 instance.
        sent = 0; got = 0; cyc = 0;
        rand_block(m_save, h_save, n_save);
        m_in = m_save; h_in = h_save; nonce_in = n_save;
        iv4 = 1;
        while ((sent < NRAND || sb.size() != 0) && cyc < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            fin  = iv4 && ir4;
            fout = ov4 && out_ready;
            if (fout) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk_w("rand_W", w4, e.w);
                    chk("rand_H", h4, e.h);
                    chk("rand_nonce", no4, e.n);
                    got++;
                end
            end
            if (fin) begin
                e.w = model_w(m_in); e.h = h_in; e.n = nonce_in;
                sb.push_back(e);
                sent++;
            end
            step;
            cyc++;
            if (fin) begin
                if (sent < NRAND) begin
                    rand_block(m_save, h_save, n_save);
                    m_in = m_save; h_in = h_save; nonce_in = n_save;
                end else begin
                    iv4 = 0;
                end
            end
        end
        chk("rand_out_count", got, NRAND);
        chk("rand_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
